// File: rtl/uart_receiver_if.sv
// Serial receive port bundle: the RxD pin in, received byte and status strobes out.
// The master modport is the receiver; the slave modport is the line driver and byte consumer.
interface uart_receiver_if;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_error;
  logic       RxD_busy;

  modport master (
    input  RxD,
    output RxD_data,
    output RxD_data_ready,
    output RxD_frame_error,
    output RxD_busy
  );

  modport slave (
    output RxD,
    input  RxD_data,
    input  RxD_data_ready,
    input  RxD_frame_error,
    input  RxD_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling from a phase-accumulator tick, mid-bit start
// validation, one-cycle data-ready and framing-error strobes.
module uart_receiver #(
  parameter int ClkFrequency = 12000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.master rx
);

  // Rounded increment so the carry rate approximates Baud*Oversampling.
  localparam longint unsigned INC_WIDE =
    ((longint'(Baud) * longint'(Oversampling) * 64'd65536) + longint'(ClkFrequency / 2))
    / longint'(ClkFrequency);
  localparam logic [16:0] INC = 17'(INC_WIDE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [1:0]  sync_r;
  logic        rx_s;
  logic [16:0] acc_r;
  logic        tick_s;

  state_t      state_r, state_s;
  logic [3:0]  os_cnt_r, os_cnt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  sr_r, sr_s;
  logic [7:0]  data_r, data_s;
  logic        ready_r, ready_s;
  logic        ferr_r, ferr_s;
  logic        busy_r, busy_s;

  assign rx_s   = sync_r[1];
  assign tick_s = acc_r[16];

  // Two-flop synchronizer on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx.RxD};
    end
  end

  // Free-running phase accumulator; the carry bit is the oversampling tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 17'd0;
    end else begin
      acc_r <= {1'b0, acc_r[15:0]} + INC;
    end
  end

  // Frame state, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      os_cnt_r  <= 4'd0;
      bit_cnt_r <= 3'd0;
      sr_r      <= 8'h00;
      data_r    <= 8'h00;
      ready_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      os_cnt_r  <= os_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      sr_r      <= sr_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      ferr_r    <= ferr_s;
      busy_r    <= busy_s;
    end
  end

  // Next-state and next-output decode; all decisions happen on tick cycles only.
  always_comb begin
    state_s   = state_r;
    os_cnt_s  = os_cnt_r;
    bit_cnt_s = bit_cnt_r;
    sr_s      = sr_r;
    data_s    = data_r;
    ready_s   = 1'b0;
    ferr_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tick_s && !rx_s) begin
          state_s  = ST_START;
          os_cnt_s = 4'd0;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_s) begin
          if (os_cnt_r == 4'd7) begin
            os_cnt_s  = 4'd0;
            bit_cnt_s = 3'd0;
            if (rx_s) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            os_cnt_s = os_cnt_r + 4'd1;
          end
        end else begin
          os_cnt_s = os_cnt_r;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          os_cnt_s = os_cnt_r + 4'd1;
          if (os_cnt_r == 4'd15) begin
            sr_s = {rx_s, sr_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_s  = ST_STOP;
              os_cnt_s = 4'd0;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            sr_s = sr_r;
          end
        end else begin
          os_cnt_s = os_cnt_r;
        end
      end

      ST_STOP: begin
        if (tick_s) begin
          os_cnt_s = os_cnt_r + 4'd1;
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (os_cnt_r == 4'd15) begin
            if (rx_s) begin
              data_s  = sr_r;
              ready_s = 1'b1;
              state_s = ST_IDLE;
            end else begin
              ferr_s  = 1'b1;
              state_s = ST_BREAK;
            end
          end else begin
            state_s = ST_STOP;
          end
        end else begin
          os_cnt_s = os_cnt_r;
        end
      end

      ST_BREAK: begin
        if (tick_s && rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  assign rx.RxD_data        = data_r;
  assign rx.RxD_data_ready  = ready_r;
  assign rx.RxD_frame_error = ferr_r;
  assign rx.RxD_busy        = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written
// glitch, framing-error, back-to-back and mid-frame reset sequences, scoreboard-checked.
module tb_uart_receiver;

  localparam int BIT_NOM  = 104;  // 12 MHz / 115200
  localparam int BIT_FAST = 101;  // Baud x 1.03
  localparam int BIT_SLOW = 107;  // Baud x 0.97

  typedef struct {
    logic [7:0] data;
    int         bit_cyc;
    int         gap;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  uart_receiver_if rx_if();

  uart_receiver #(
    .ClkFrequency(12000000),
    .Baud(115200),
    .Oversampling(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx_if.master)
  );

  int   checks_n = 0;
  int   errors_n = 0;
  int   cyc = 0;
  int   n_ready = 0;
  int   n_err = 0;
  int   last_ready_cyc = 0;
  int   edge_cyc = 0;
  logic busy_seen = 1'b0;
  logic [7:0] model_last = 8'h00;
  exp_t sb[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx_if.RxD = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v);
    @(negedge clk);
    rx_if.RxD = 1'b0;
    edge_cyc = cyc;
    repeat (bc - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    drive_bit(stop_v, bc);
  endtask

  task automatic push_good(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    sb.push_back(e);
    model_last = b;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = model_last;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int base_r;
    int base_e;
    int lat;

    vecs[0] = '{data: 8'h61, bit_cyc: BIT_NOM,  gap: 300};
    vecs[1] = '{data: 8'h0F, bit_cyc: BIT_FAST, gap: 300};
    vecs[2] = '{data: 8'h0F, bit_cyc: BIT_SLOW, gap: 300};
    vecs[3] = '{data: 8'h00, bit_cyc: BIT_NOM,  gap: 200};
    vecs[4] = '{data: 8'hFF, bit_cyc: BIT_NOM,  gap: 200};
    vecs[5] = '{data: 8'h80, bit_cyc: BIT_FAST, gap: 200};
    vecs[6] = '{data: 8'h01, bit_cyc: BIT_SLOW, gap: 200};

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rx_if.RxD_data_ready || rx_if.RxD_frame_error) begin
            chk("strobe_excl", {31'd0, rx_if.RxD_data_ready & rx_if.RxD_frame_error}, 0);
            chk("unexpected_strobe", {31'd0, sb.size() == 0}, 0);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("strobe_kind", {31'd0, rx_if.RxD_frame_error}, {31'd0, e.is_err});
              chk("rx_data", {24'd0, rx_if.RxD_data}, {24'd0, e.data});
            end
            if (rx_if.RxD_data_ready) begin
              n_ready++;
              last_ready_cyc = cyc;
            end
            if (rx_if.RxD_frame_error) n_err++;
          end
          if (rx_if.RxD_busy) busy_seen = 1'b1;
        end
      end
    join_none

    rst = 1'b1;
    rx_if.RxD = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data",  {24'd0, rx_if.RxD_data}, 0);
    chk("rst_ready", {31'd0, rx_if.RxD_data_ready}, 0);
    chk("rst_ferr",  {31'd0, rx_if.RxD_frame_error}, 0);
    chk("rst_busy",  {31'd0, rx_if.RxD_busy}, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    // Table of single frames at nominal and +/-3% rates.
    for (int v = 0; v < 7; v++) begin
      push_good(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].bit_cyc, 1'b1);
      wait_drain(400);
      if (v == 0) begin
        lat = last_ready_cyc - edge_cyc;
        chk("latency_window", {31'd0, (lat >= 985 && lat <= 1005)}, 1);
      end
      repeat (vecs[v].gap) @(negedge clk);
    end
    chk("no_err_table", n_err, 0);

    // Back-to-back character loop, one stop bit, no idle between frames.
    for (int r = 0; r < 2; r++) begin
      for (int c = 8'h61; c <= 8'h6B; c++) begin
        push_good(8'(c));
        send_frame(8'(c), BIT_NOM, 1'b1);
      end
    end
    wait_drain(400);
    chk("b2b_ready_count", n_ready, 7 + 22);

    // Short low glitch must be rejected as a false start.
    repeat (300) @(negedge clk);
    base_r = n_ready;
    base_e = n_err;
    busy_seen = 1'b0;
    @(negedge clk);
    rx_if.RxD = 1'b0;
    repeat (20) @(negedge clk);
    rx_if.RxD = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_busy_seen", {31'd0, busy_seen}, 1);
    chk("glitch_busy_low", {31'd0, rx_if.RxD_busy}, 0);
    chk("glitch_no_ready", n_ready - base_r, 0);
    chk("glitch_no_err", n_err - base_e, 0);
    push_good(8'hA5);
    send_frame(8'hA5, BIT_NOM, 1'b1);
    wait_drain(400);
    repeat (200) @(negedge clk);

    // Framing error followed by a line held low for two frames.
    base_r = n_ready;
    base_e = n_err;
    push_err();
    send_frame(8'h3C, BIT_NOM, 1'b0);
    wait_drain(400);
    repeat (2 * 10 * BIT_NOM) @(negedge clk);
    chk("break_one_err", n_err - base_e, 1);
    chk("break_no_ready", n_ready - base_r, 0);
    chk("break_data_held", {24'd0, rx_if.RxD_data}, 32'h0000_00A5);
    chk("break_busy", {31'd0, rx_if.RxD_busy}, 1);
    rx_if.RxD = 1'b1;
    repeat (BIT_NOM) @(negedge clk);
    chk("break_exit_idle", {31'd0, rx_if.RxD_busy}, 0);
    push_good(8'h55);
    send_frame(8'h55, BIT_NOM, 1'b1);
    wait_drain(400);
    repeat (200) @(negedge clk);

    // Reset in the middle of data bit 4.
    drive_bit(1'b0, BIT_NOM);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, BIT_NOM);
    @(negedge clk);
    rx_if.RxD = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", {31'd0, rx_if.RxD_busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data",  {24'd0, rx_if.RxD_data}, 0);
    chk("mid_rst_ready", {31'd0, rx_if.RxD_data_ready}, 0);
    chk("mid_rst_ferr",  {31'd0, rx_if.RxD_frame_error}, 0);
    chk("mid_rst_busy",  {31'd0, rx_if.RxD_busy}, 0);
    repeat (5) @(negedge clk);
    rx_if.RxD = 1'b1;
    rst = 1'b0;
    model_last = 8'h00;
    repeat (BIT_NOM) @(negedge clk);
    push_good(8'hFF);
    send_frame(8'hFF, BIT_NOM, 1'b1);
    wait_drain(400);
    repeat (100) @(negedge clk);
    chk("total_err", n_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
